fifo_rd_packer: RTL

Downstream consumer of the narrow FIFO. It pops DATA_WIDTH-bit entries and packs LANES of them into one wide word. The word is presented on a valid/ready output stream. It sits between the FIFO's read side (rd/empty/data_out) and any wide-bus consumer, and owns the FIFO's rd strobe.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_rd_packer_if.sv | 50 +++++
 rtl/fifo_rd_packer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the narrow FIFO and its wide read-side packer.
// Holds the default geometry, the fixed FIFO read latency and the packer FSM states.
package fifo_pkg;

    // Default geometry shared by the FIFO and the packer
    localparam int unsigned DEFAULT_DATA_WIDTH = 2;
    localparam int unsigned DEFAULT_LANES      = 4;

    // FIFO data_out is valid exactly this many cycles after rd
    localparam int unsigned RD_LATENCY = 1;

    // Packer FSM: collect lanes, then present the packed word
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    // Width of a counter that must be able to hold the value 'lanes'
    function automatic int unsigned lane_cnt_width(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bundle between the FIFO read side, the packer and the wide consumer.
// master: the packer (drives fifo_rd and the output stream).
// slave:  the environment (FIFO read port plus wide consumer).
// The flush signal exists only when PACK_FLUSH_EN is defined.
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned LANES      = DEFAULT_LANES
);

    localparam int unsigned OUT_WIDTH = DATA_WIDTH * LANES;
    localparam int unsigned CNT_W     = lane_cnt_width(LANES);

    // FIFO read side
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd;

    // Wide output stream
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [CNT_W-1:0]      out_lanes;

`ifdef PACK_FLUSH_EN
    logic                  flush;

    modport master (
        input  fifo_empty, fifo_data, out_ready, flush,
        output fifo_rd, out_valid, out_data, out_lanes
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready, flush,
        input  fifo_rd, out_valid, out_data, out_lanes
    );
`else
    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd, out_valid, out_data, out_lanes
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd, out_valid, out_data, out_lanes
    );
`endif

endinterface

// File: rtl/fifo_rd_packer.sv
// Pops DATA_WIDTH-bit entries from the narrow FIFO and packs LANES of them into one
// wide word presented on a valid/ready stream. First-popped entry lands in the LSBs.
// Optional feature macro: PACK_FLUSH_EN adds a flush input that closes a partial word.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned LANES      = DEFAULT_LANES
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_packer_if.master  bus
);

    localparam int unsigned      OUT_WIDTH = DATA_WIDTH * LANES;
    localparam int unsigned      CNT_W     = lane_cnt_width(LANES);
    localparam logic [CNT_W-1:0] LANES_CNT = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Elaboration-time guards on the geometry and the FIFO timing this block assumes
    if (LANES < 2) begin : g_bad_lanes
        $error("fifo_rd_packer: LANES must be at least 2");
    end
    if (RD_LATENCY != 1) begin : g_bad_latency
        $error("fifo_rd_packer: only a FIFO read latency of 1 is supported");
    end

    pack_state_e           r_state;
    pack_state_e           w_state_next;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_captured;
    logic                  r_rd_pend;
    logic [OUT_WIDTH-1:0]  r_lanes;
    logic                  r_out_valid;
    logic [CNT_W-1:0]      r_out_lanes;

    logic                  w_fifo_rd;
    logic                  w_handshake;
    logic [CNT_W-1:0]      w_captured_next;
    logic                  w_word_full;
    logic                  w_close;

    // Accepted word leaves the block; out_ready alone is ignored
    assign w_handshake     = r_out_valid && bus.out_ready;

    // Lane count after this edge, counting the entry whose data arrives now
    assign w_captured_next = r_captured + CNT_W'(r_rd_pend);

    // The capture landing on this edge fills the last lane
    assign w_word_full     = (r_state == FILL) && r_rd_pend && (w_captured_next == LANES_CNT);

`ifdef PACK_FLUSH_EN
    logic r_flush_req;
    logic w_flush_accept;

    // A flush only means something once at least one entry has been issued, and a
    // flush coinciding with a natural word close is redundant
    assign w_flush_accept = (r_state == FILL) && bus.flush && !r_flush_req &&
                            (w_captured_next != '0) && !w_word_full;

    // With reads blocked by the request, the only entry still in flight (if any) is
    // captured on this edge, so the word can be closed on the same edge
    assign w_close = w_word_full || ((r_state == FILL) && r_flush_req);

    // Flush request: latched in FILL, released only by the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_req <= 1'b0;
        end else if (w_handshake) begin
            r_flush_req <= 1'b0;
        end else if (w_flush_accept) begin
            r_flush_req <= 1'b1;
        end
    end
`else
    assign w_close = w_word_full;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: FILL until the word closes, HOLD until it is accepted
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            FILL: if (w_close)     w_state_next = HOLD;
            HOLD: if (w_handshake) w_state_next = FILL;
        endcase
    end

    // FSM output: read strobe, never raised against an empty FIFO or a full issue count
    always_comb begin
        w_fifo_rd = 1'b0;
        if ((r_state == FILL) && !bus.fifo_empty && (r_issued < LANES_CNT)) begin
            w_fifo_rd = 1'b1;
        end
`ifdef PACK_FLUSH_EN
        if (r_flush_req) begin
            w_fifo_rd = 1'b0;
        end
`endif
    end

    // Read-pending flag: registered copy of the strobe, marks data arriving next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_fifo_rd;
        end
    end

    // Issue/capture counters, lane register and output stream registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued    <= '0;
            r_captured  <= '0;
            r_lanes     <= '0;
            r_out_valid <= 1'b0;
            r_out_lanes <= '0;
        end else if (w_handshake) begin
            // Clearing lanes here keeps unused upper lanes at zero on a short word
            r_issued    <= '0;
            r_captured  <= '0;
            r_lanes     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_fifo_rd) begin
                r_issued <= r_issued + CNT_ONE;
            end
            if (r_rd_pend) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (r_captured == CNT_W'(i)) begin
                        r_lanes[i*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_data;
                    end
                end
                r_captured <= w_captured_next;
            end
            if (w_close) begin
                r_out_valid <= 1'b1;
                r_out_lanes <= w_captured_next;
            end
        end
    end

    assign bus.fifo_rd   = w_fifo_rd;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_lanes;
    assign bus.out_lanes = r_out_lanes;

endmodule
